synapse_current_integrator: RTL and testbench

- Upstream stage of the LIF neuron. Turns up to N_IN presynaptic spike lines into the 8-bit unsigned input current the neuron consumes.
- Each spike line has a programmable signed weight.
- The accumulated current decays exponentially on a periodic tick and saturates to [0, 255].
- Output `current` connects directly to the neuron's current input.

---
 rtl/lif_pkg.sv | 34 +++
 rtl/synapse_current_integrator_if.sv | 32 +++
 rtl/decay_tick_gen.sv | 34 +++
 rtl/synapse_current_integrator.sv | 98 +++++++++
 tb/tb_synapse_current_integrator.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/lif_pkg.sv
// Shared types and saturation helper for the synapse integrator and the LIF neuron.
// Both blocks clamp a signed sum onto the 8-bit unsigned current range.
package lif_pkg;

    localparam int CUR_W    = 8;
    localparam int CUR_MAX  = 255;
    localparam int WEIGHT_W = 8;

    typedef logic [CUR_W-1:0]           cur_t;
    typedef logic signed [WEIGHT_W-1:0] weight_t;

    typedef struct packed {
        cur_t value;
        logic hi;
        logic lo;
    } sat_res_t;

    // Callers sign-extend their sum to 32 bits, so one helper serves any adder width.
    function automatic sat_res_t sat_u8(input logic signed [31:0] sum);
        sat_res_t res;
        res.hi    = 1'b0;
        res.lo    = 1'b0;
        res.value = sum[CUR_W-1:0];
        if (sum > CUR_MAX) begin
            res.value = cur_t'(CUR_MAX);
            res.hi    = 1'b1;
        end else if (sum < 0) begin
            res.value = '0;
            res.lo    = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/synapse_current_integrator_if.sv
// Control, spike, weight-write and current/status signals of the synapse integrator.
// The master side drives spikes and weight writes; the slave side returns the current.
interface synapse_current_integrator_if
    import lif_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int W_WIDTH = 8
);
    localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic               en;
    logic               clear;
    logic [N_IN-1:0]    spike_in;
    logic               w_we;
    logic [AW-1:0]      w_addr;
    logic [W_WIDTH-1:0] w_data;
    cur_t               current;
    logic               sat_hi;
    logic               sat_lo;
    logic               decay_tick;

    modport master (
        output en, clear, spike_in, w_we, w_addr, w_data,
        input  current, sat_hi, sat_lo, decay_tick
    );

    modport slave (
        input  en, clear, spike_in, w_we, w_addr, w_data,
        output current, sat_hi, sat_lo, decay_tick
    );

endinterface

// File: rtl/decay_tick_gen.sv
// Period counter for the exponential decay: o_tick is high in the enabled cycle
// that consumes the last count of the period, so the update applies decay there.
module decay_tick_gen #(
    parameter int DECAY_PERIOD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clear,
    output logic o_tick
);

    localparam int             CW   = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DECAY_PERIOD - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign o_tick = i_en && !i_clear && w_last;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order in which always blocks run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/synapse_current_integrator.sv
// Weighted spike integrator with periodic exponential decay, feeding the LIF neuron
// an 8-bit saturated current through a single output register.
module synapse_current_integrator
    import lif_pkg::*;
#(
    parameter int N_IN         = 4,
    parameter int W_WIDTH      = 8,
    parameter int DECAY_SHIFT  = 3,
    parameter int DECAY_PERIOD = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    synapse_current_integrator_if.slave   bus
);

    localparam int AW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int SUM_W = ((W_WIDTH > CUR_W) ? W_WIDTH : CUR_W) + AW + 2;

    logic signed [W_WIDTH-1:0] r_weight [N_IN];
    cur_t                      r_current;
    logic                      r_sat_hi;
    logic                      r_sat_lo;
    logic                      r_decay_tick;

    logic                      w_tick;
    logic signed [SUM_W-1:0]   w_spike_sum;
    logic signed [SUM_W-1:0]   w_cur_ext;
    logic signed [SUM_W-1:0]   w_decay;
    logic signed [SUM_W-1:0]   w_next;
    sat_res_t                  w_sat;

    decay_tick_gen #(
        .DECAY_PERIOD (DECAY_PERIOD)
    ) u_decay_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (bus.en),
        .i_clear (bus.clear),
        .o_tick  (w_tick)
    );

    // NOTE: every variable in this block gets a default before any condition,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_spike_sum = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (bus.spike_in[i]) begin
                w_spike_sum = w_spike_sum + SUM_W'(r_weight[i]);
            end
        end
        // Decay is taken from the pre-update current, before spikes are added.
        w_cur_ext = SUM_W'(r_current);
        w_decay   = w_tick ? SUM_W'(r_current >> DECAY_SHIFT) : '0;
        w_next    = w_cur_ext - w_decay + w_spike_sum;
        w_sat     = sat_u8(32'(w_next));
    end

    // NOTE: the weight file is a handful of flops that must read zero right after
    // reset, so it is reset explicitly instead of being inferred as RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                r_weight[i] <= '0;
            end
        end else if (bus.w_we && (int'(bus.w_addr) < N_IN)) begin
            r_weight[bus.w_addr] <= bus.w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_current    <= '0;
            r_sat_hi     <= 1'b0;
            r_sat_lo     <= 1'b0;
            r_decay_tick <= 1'b0;
        end else if (bus.clear) begin
            r_current    <= '0;
            r_sat_hi     <= 1'b0;
            r_sat_lo     <= 1'b0;
            r_decay_tick <= 1'b0;
        end else if (bus.en) begin
            r_current    <= w_sat.value;
            r_sat_hi     <= w_sat.hi;
            r_sat_lo     <= w_sat.lo;
            r_decay_tick <= w_tick;
        end else begin
            r_sat_hi     <= 1'b0;
            r_sat_lo     <= 1'b0;
            r_decay_tick <= 1'b0;
        end
    end

    assign bus.current    = r_current;
    assign bus.sat_hi     = r_sat_hi;
    assign bus.sat_lo     = r_sat_lo;
    assign bus.decay_tick = r_decay_tick;

endmodule

// File: tb/tb_synapse_current_integrator.sv
// Directed and randomized checks of the synapse integrator against an arithmetic
// model that tracks current, weights and decay phase as plain integers.
module tb_synapse_current_integrator;
    import lif_pkg::*;

    localparam int N_IN         = 4;
    localparam int W_WIDTH      = 8;
    localparam int DECAY_SHIFT  = 3;
    localparam int DECAY_PERIOD = 4;
    localparam int AW           = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    synapse_current_integrator_if #(.N_IN(N_IN), .W_WIDTH(W_WIDTH)) bus ();

    synapse_current_integrator #(
        .N_IN         (N_IN),
        .W_WIDTH      (W_WIDTH),
        .DECAY_SHIFT  (DECAY_SHIFT),
        .DECAY_PERIOD (DECAY_PERIOD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int m_cur;
    int m_w [N_IN];
    int m_phase;
    bit m_hi, m_lo, m_tick;

    task automatic check(input string tag, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_cur   = 0;
        m_phase = 0;
        m_hi    = 0;
        m_lo    = 0;
        m_tick  = 0;
        for (int i = 0; i < N_IN; i++) m_w[i] = 0;
    endtask

    // One clock edge of the intended behaviour, using the inputs applied to it.
    task automatic model_edge();
        int sum;
        int nxt;
        bit tick;
        if (bus.clear) begin
            m_cur = 0; m_phase = 0; m_hi = 0; m_lo = 0; m_tick = 0;
        end else if (bus.en) begin
            tick    = (m_phase == DECAY_PERIOD - 1);
            m_phase = (m_phase + 1) % DECAY_PERIOD;
            sum = 0;
            for (int i = 0; i < N_IN; i++) if (bus.spike_in[i]) sum += m_w[i];
            nxt    = m_cur - (tick ? m_cur / (1 << DECAY_SHIFT) : 0) + sum;
            m_hi   = (nxt > 255);
            m_lo   = (nxt < 0);
            m_cur  = m_hi ? 255 : (m_lo ? 0 : nxt);
            m_tick = tick;
        end else begin
            m_hi = 0; m_lo = 0; m_tick = 0;
        end
        if (bus.w_we && int'(bus.w_addr) < N_IN) m_w[bus.w_addr] = int'($signed(bus.w_data));
    endtask

    task automatic drive(input bit en, input bit clr, input logic [N_IN-1:0] sp,
                         input bit we = 0, input int addr = 0, input int data = 0);
        bus.en       = en;
        bus.clear    = clr;
        bus.spike_in = sp;
        bus.w_we     = we;
        bus.w_addr   = AW'(addr);
        bus.w_data   = W_WIDTH'(data);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".cur"},  int'(bus.current),    m_cur);
        check({tag, ".hi"},   int'(bus.sat_hi),     int'(m_hi));
        check({tag, ".lo"},   int'(bus.sat_lo),     int'(m_lo));
        check({tag, ".tick"}, int'(bus.decay_tick), int'(m_tick));
    endtask

    task automatic write_w(input int addr, input int data);
        drive(1, 0, '0, 1, addr, data);
        cycle("wr");
        drive(1, 0, '0);
    endtask

    task automatic do_clear();
        drive(1, 1, '0);
        cycle("clr");
        drive(1, 0, '0);
    endtask

    initial begin
        int tick_vals[$];
        int exp_decay[4] = '{35, 31, 28, 25};
        int held;

        rst_n = 1'b0;
        drive(0, 0, '0);
        model_reset();
        #12;
        check("rst.cur",  int'(bus.current),    0);
        check("rst.hi",   int'(bus.sat_hi),     0);
        check("rst.lo",   int'(bus.sat_lo),     0);
        check("rst.tick", int'(bus.decay_tick), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(1, 0, N_IN'($urandom_range(0, 15)));
            cycle("hold");
        end
        check("hold.zero", int'(bus.current), 0);

        // Decay sequence 40 -> 35 -> 31 -> 28 -> 25, one tick per period.
        do_clear();
        write_w(0, 40);
        drive(1, 0, 4'b0001);
        cycle("decay.spike");
        check("decay.first", int'(bus.current), 40);
        drive(1, 0, '0);
        for (int i = 0; i < 4 * DECAY_PERIOD; i++) begin
            cycle("decay");
            if (bus.decay_tick) tick_vals.push_back(int'(bus.current));
        end
        check("decay.nticks", tick_vals.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("decay.val%0d", i), (i < tick_vals.size()) ? tick_vals[i] : -1, exp_decay[i]);

        // Saturate high.
        do_clear();
        write_w(0, 100);
        write_w(1, 100);
        drive(1, 0, 4'b0011);
        cycle("sathi.1");
        check("sathi.200", int'(bus.current), 200);
        cycle("sathi.2");
        check("sathi.255", int'(bus.current), 255);
        check("sathi.pulse", int'(bus.sat_hi), 1);
        cycle("sathi.3");
        check("sathi.keep", int'(bus.current), 255);

        // Saturate low.
        do_clear();
        write_w(2, -50);
        write_w(3, 30);
        drive(1, 0, 4'b1000);
        cycle("satlo.set");
        check("satlo.30", int'(bus.current), 30);
        drive(1, 0, 4'b0100);
        cycle("satlo.neg");
        check("satlo.zero", int'(bus.current), 0);
        check("satlo.pulse", int'(bus.sat_lo), 1);
        check("satlo.nohi", int'(bus.sat_hi), 0);

        // Write in the same cycle as a spike uses the old weight.
        do_clear();
        write_w(0, 10);
        drive(1, 0, 4'b0001, 1, 0, 90);
        cycle("haz.old");
        check("haz.old10", int'(bus.current), 10);
        drive(1, 0, 4'b0001);
        cycle("haz.new");

        held = int'(bus.current);
        drive(0, 0, 4'b1111);
        for (int i = 0; i < 5; i++) cycle("en0");
        check("en0.hold", int'(bus.current), held);

        drive(1, 1, 4'b1111);
        cycle("clr.cur");
        check("clr.zero", int'(bus.current), 0);
        drive(1, 0, 4'b0001);
        cycle("clr.wkeep");
        check("clr.w90", int'(bus.current), 90);

        // Asynchronous reset between edges.
        do_clear();
        write_w(0, 120);
        drive(1, 0, 4'b0001);
        cycle("arst.set");
        check("arst.120", int'(bus.current), 120);
        drive(1, 0, '0);
        @(posedge clk);
        model_edge();
        #2 rst_n = 1'b0;
        #1;
        check("arst.cur", int'(bus.current), 0);
        model_reset();
        #3 rst_n = 1'b1;
        drive(1, 0, 4'b0001);
        cycle("arst.w0");
        check("arst.wzero", int'(bus.current), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
                  N_IN'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, N_IN - 1)), int'($urandom_range(0, 255)));
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
